cva5_fifo_multi_channel: RTL

// - N independent show-ahead FIFOs in one block. Each channel has its own push/pop, occupancy and status.
// - Successor to the single-channel small FIFO used ahead of the divider.
// - Adds non-power-of-2 depth, occupancy count, almost-full, per-channel flush and overflow/underflow protection.
// - Used where several issue streams (e.g. per-ID divider requests) need private queues.

---
 rtl/cva5_fifo_multi_channel.sv | 116 +++++++++++
 1 files changed

// File: rtl/cva5_fifo_multi_channel.sv
// Bank of independent show-ahead FIFOs. Each channel has private storage, occupancy,
// status and sticky overflow/underflow flags, plus a flush that beats push and pop.
module cva5_fifo_multi_channel #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned AF_THRESHOLD = 3,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS-1:0]          push,
    input  logic [NUM_CHANNELS-1:0]          pop,
    input  logic [NUM_CHANNELS-1:0]          flush,
    input  logic                             err_clear,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS-1:0]          valid,
    output logic [NUM_CHANNELS-1:0]          full,
    output logic [NUM_CHANNELS-1:0]          almost_full,
    output logic [NUM_CHANNELS*CW-1:0]       count,
    output logic [NUM_CHANNELS-1:0]          overflow,
    output logic [NUM_CHANNELS-1:0]          underflow
);

    // Wraps at DEPTH-1 so non-power-of-2 depths use every slot; DEPTH==1 pins at 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] mem_d [DEPTH];
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         count_q, count_d;
        logic                  overflow_q, overflow_d;
        logic                  underflow_q, underflow_d;
        logic                  push_acc, pop_acc;
        logic                  push_drop, pop_drop;
        logic [DATA_WIDTH-1:0] wdata;

        assign wdata = data_in[c*DATA_WIDTH +: DATA_WIDTH];

        always_comb begin
            // Acceptance is judged on the registered count only.
            pop_acc   = pop[c] && !flush[c] && (count_q != '0);
            push_acc  = push[c] && !flush[c] && ((count_q != CW'(DEPTH)) || pop_acc);
            pop_drop  = pop[c] && !flush[c] && (count_q == '0);
            push_drop = push[c] && !flush[c] && !push_acc;

            mem_d = mem_q;
            if (push_acc) begin
                mem_d[wr_ptr_q] = wdata;
            end

            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (flush[c]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
                if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d = count_q + CW'(push_acc) - CW'(pop_acc);
            end

            // A fresh error in the same cycle as err_clear keeps the flag set.
            overflow_d  = (overflow_q && !err_clear) || push_drop;
            underflow_d = (underflow_q && !err_clear) || pop_drop;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                count_q     <= count_d;
                overflow_q  <= overflow_d;
                underflow_q <= underflow_d;
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end

        assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];
        assign count[c*CW +: CW] = count_q;
        assign valid[c]          = (count_q != '0);
        assign full[c]           = (count_q == CW'(DEPTH));
        assign almost_full[c]    = (count_q >= CW'(AF_THRESHOLD));
        assign overflow[c]       = overflow_q;
        assign underflow[c]      = underflow_q;

        a_push_drop: assert property (@(posedge clk) disable iff (!rst) !push_drop)
            else $warning("fifo channel %0d: push dropped while full", c);
        a_pop_drop: assert property (@(posedge clk) disable iff (!rst) !pop_drop)
            else $warning("fifo channel %0d: pop dropped while empty", c);
        a_count_range: assert property (@(posedge clk) disable iff (!rst)
            count_q <= CW'(DEPTH))
            else $error("fifo channel %0d: count out of range", c);
    end

endmodule
